imem_boot_loader: RTL

Streams a program image into the processor's word-indexed instruction memory from a byte-wide valid/ready source, holding the core in reset until the image is complete. Sits upstream of the instruction-fetch side of the single-cycle RISC-V top: its write port drives the instruction memory, and its `core_reset` output gates the core's reset. Replaces hierarchical instruction-memory preloading for image-driven and multi-program runs.

---
 rtl/boot_pkg.sv | 17 +
 rtl/byte_word_packer.sv | 53 +++++
 rtl/imem_boot_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

   localparam int WORD_BYTES = 4;
   localparam int LEN_W      = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } boot_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles little-endian bytes into 32-bit words; pulses o_word_valid
// the cycle after the final byte of each word is accepted.
module byte_word_packer
   import boot_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic        o_last_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   localparam int CNT_W = $clog2(WORD_BYTES);

   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_shift;
   logic [31:0]      r_word;
   logic             r_word_valid;
   logic [31:0]      w_assembled;

   // First byte of a word ends up in bits [7:0] after the last shift.
   assign w_assembled = {i_byte, r_shift[31:8]};
   assign o_last_byte = (r_cnt == CNT_W'(WORD_BYTES - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt        <= '0;
         r_shift      <= '0;
         r_word       <= '0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_clear) begin
            r_cnt   <= '0;
            r_shift <= '0;
         end else if (i_byte_valid) begin
            r_shift <= w_assembled;
            r_cnt   <= r_cnt + 1'b1;
            if (o_last_byte) begin
               r_word_valid <= 1'b1;
               r_word       <= w_assembled;
            end
         end
      end
   end

   assign o_word_valid = r_word_valid;
   assign o_word       = r_word;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding
// the core in reset. Optional trailing XOR checksum: BOOT_CHECKSUM_EN.
//   state  | meaning
//   IDLE   | waiting for start after reset
//   LEN_LO | expecting low byte of word count
//   LEN_HI | expecting high byte; zero/overflow decided here
//   DATA   | packing and writing image words
//   CSUM   | expecting XOR of all preceding frame bytes
//   DONE   | image good, core released
//   ERR    | overflow or bad checksum, core held in reset
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH),
   parameter int BASE_ADDR  = 0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_data,
   output logic              o_rx_ready,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_core_reset,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

`ifdef BOOT_CHECKSUM_EN
   localparam boot_state_t ST_AFTER_DATA = ST_CSUM;
   localparam logic        CSUM_EN       = 1'b1;
`else
   localparam boot_state_t ST_AFTER_DATA = ST_DONE;
   localparam logic        CSUM_EN       = 1'b0;
`endif

   localparam logic [LEN_W:0]    BASE_EXT  = (LEN_W + 1)'(BASE_ADDR);
   localparam logic [LEN_W:0]    DEPTH_EXT = (LEN_W + 1)'(IMEM_DEPTH);
   localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);

   boot_state_t       r_state;
   logic              r_rx_ready;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [ADDR_W-1:0] r_ptr;
   logic [LEN_W-1:0]  r_remain;
   logic [7:0]        r_len_lo;
   logic              r_core_reset;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic              w_fire;
   logic              w_data_fire;
   logic              w_start;
   logic              w_last_byte;
   logic [LEN_W-1:0]  w_len;
   logic              w_overflow;

   assign w_fire      = i_rx_valid && r_rx_ready;
   assign w_data_fire = w_fire && (r_state == ST_DATA);
   assign w_start     = i_start && !r_busy;
   assign w_len       = {i_rx_data, r_len_lo};
   // 17-bit sum so a large N cannot wrap past the depth check.
   assign w_overflow  = (BASE_EXT + {1'b0, w_len}) > DEPTH_EXT;

   byte_word_packer u_packer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (w_start),
      .i_byte_valid (w_data_fire),
      .i_byte       (i_rx_data),
      .o_last_byte  (w_last_byte),
      .o_word_valid (o_imem_we),
      .o_word       (o_imem_wdata)
   );

`ifdef BOOT_CHECKSUM_EN
   logic [7:0] r_csum;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_csum <= '0;
      end else if (w_start) begin
         r_csum <= '0;
      end else if (w_fire && (r_state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA})) begin
         r_csum <= r_csum ^ i_rx_data;
      end
   end
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_rx_ready   <= 1'b0;
         r_imem_addr  <= '0;
         r_ptr        <= '0;
         r_remain     <= '0;
         r_len_lo     <= '0;
         r_core_reset <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else if (w_start) begin
         r_state      <= ST_LEN_LO;
         r_rx_ready   <= 1'b1;
         r_core_reset <= 1'b1;
         r_busy       <= 1'b1;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_ptr        <= BASE_PTR;
      end else begin
         case (r_state)
            ST_IDLE: ;
            ST_LEN_LO: begin
               if (w_fire) begin
                  r_len_lo <= i_rx_data;
                  r_state  <= ST_LEN_HI;
               end
            end
            ST_LEN_HI: begin
               if (w_fire) begin
                  if (w_len == '0) begin
                     r_state    <= ST_AFTER_DATA;
                     r_rx_ready <= CSUM_EN;
                  end else if (w_overflow) begin
                     r_state    <= ST_ERR;
                     r_rx_ready <= 1'b0;
                  end else begin
                     r_remain <= w_len;
                     r_state  <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_data_fire && w_last_byte) begin
                  r_imem_addr <= r_ptr;
                  r_ptr       <= r_ptr + 1'b1;
                  r_remain    <= r_remain - 1'b1;
                  if (r_remain == LEN_W'(1)) begin
                     r_state    <= ST_AFTER_DATA;
                     r_rx_ready <= CSUM_EN;
                  end
               end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
               if (w_fire) begin
                  r_rx_ready <= 1'b0;
                  r_state    <= (i_rx_data == r_csum) ? ST_DONE : ST_ERR;
               end
            end
`endif
            ST_DONE: begin
               r_core_reset <= 1'b0;
               r_done       <= 1'b1;
               r_busy       <= 1'b0;
            end
            ST_ERR: begin
               r_err  <= 1'b1;
               r_busy <= 1'b0;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_rx_ready <= 1'b0;
            end
         endcase
      end
   end

   assign o_rx_ready   = r_rx_ready;
   assign o_imem_addr  = r_imem_addr;
   assign o_core_reset = r_core_reset;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_err        = r_err;

endmodule
